async_crossing_source: RTL and testbench

Source (launch) end of the two-phase bundled-data clock-domain crossing. It accepts a WIDTH-bit word on a local ready/valid port and holds it stable on `io_data`. It signals each new word by toggling `io_req`, then waits until the sink's `io_ack` toggle has been synchronized into the local domain. It pairs with the receive-side synchronizer shift registers and closes the crossing from the transmitting clock domain.

---
 rtl/async_crossing_pkg.sv | 12 +
 rtl/async_ack_sync.sv | 28 ++
 rtl/async_crossing_source.sv | 102 ++++++++++
 tb/tb_async_crossing_source.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_crossing_pkg.sv
// rtl/async_crossing_pkg.sv - shared types and defaults for the async crossing source
package async_crossing_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    localparam int ASYNC_SYNC_DEPTH_DEFAULT = 3;
    localparam int ASYNC_TIMEOUT_DEFAULT    = 1024;

endpackage

// File: rtl/async_ack_sync.sv
// rtl/async_ack_sync.sv - plain flop-chain synchronizer for the two-phase ack toggle
module async_ack_sync
    import async_crossing_pkg::*;
#(
    parameter int SYNC_DEPTH = ASYNC_SYNC_DEPTH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic io_ack,
    output logic ack_s
);

    // Depths below two give no metastability protection, so clamp.
    localparam int DEPTH = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], io_ack};
        end
    end

    assign ack_s = r_sync[DEPTH-1];

endmodule

// File: rtl/async_crossing_source.sv
// rtl/async_crossing_source.sv - two-phase bundled-data CDC launch side; ASYNC_CROSSING_SOURCE_TIMEOUT_EN adds a sticky ack timeout
module async_crossing_source
    import async_crossing_pkg::*;
#(
    parameter int WIDTH          = 2,
    parameter int SYNC_DEPTH     = ASYNC_SYNC_DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = ASYNC_TIMEOUT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_req,
    output logic [WIDTH-1:0] io_data,
    input  logic             io_ack
`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
    ,
    output logic             io_timeout
`endif
);

    state_e           r_state;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_ready;
    logic             w_ack_s;
    logic             w_fire;

    async_ack_sync #(
        .SYNC_DEPTH(SYNC_DEPTH)
    ) u_ack_sync (
        .clock (clock),
        .reset (reset),
        .io_ack(io_ack),
        .ack_s (w_ack_s)
    );

    assign w_fire = (r_state == IDLE) && io_enq_valid;

    // A mismatched ack while idle is a stale/spurious toggle and is not acted on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_enq_valid) begin
                        r_data  <= io_enq_bits;
                        r_req   <= ~r_req;
                        r_state <= WAIT_ACK;
                        r_ready <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (w_ack_s == r_req) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign io_enq_ready = r_ready;
    assign io_req       = r_req;
    assign io_data      = r_data;

`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    // The flag rises on the same edge the count reaches the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_wait_cnt <= '0;
            end else if ((r_state == WAIT_ACK) && (r_wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if ((r_state == WAIT_ACK) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign io_timeout = r_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic w_unused_fire;
    assign w_unused_fire = w_fire;
`endif

endmodule

// File: tb/tb_async_crossing_source.sv
// tb/tb_async_crossing_source.sv - directed scoreboard bench for async_crossing_source (ASYNC_CROSSING_SOURCE_TIMEOUT_EN optional)
module tb_async_crossing_source;

    localparam int WIDTH      = 2;
    localparam int SYNC_DEPTH = 3;
`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 8;
`else
    localparam int TIMEOUT_CYCLES = 1024;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_enq_valid = 1'b0;
    logic             io_enq_ready;
    logic [WIDTH-1:0] io_enq_bits = '0;
    logic             io_req;
    logic [WIDTH-1:0] io_data;
    logic             io_ack = 1'b0;
`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
    logic             io_timeout;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             req_log[$];
    logic [WIDTH-1:0] words[3] = '{2'b01, 2'b11, 2'b00};

    logic             sink_en   = 1'b0;
    logic             sink_seen = 1'b0;
    int               sink_cnt  = 0;
    int               ack_cyc   = -1;
    logic             mon_req   = 1'b0;
    logic [WIDTH-1:0] mon_data  = '0;

    async_crossing_source #(
        .WIDTH         (WIDTH),
        .SYNC_DEPTH    (SYNC_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_enq_valid(io_enq_valid),
        .io_enq_ready(io_enq_ready),
        .io_enq_bits (io_enq_bits),
        .io_req      (io_req),
        .io_data     (io_data),
        .io_ack      (io_ack)
`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
        ,
        .io_timeout  (io_timeout)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Sink model: toggles ack five cycles after it sees a new req level.
    always begin
        @(posedge clock);
        #1;
        if (!reset) begin
            sink_seen = 1'b0;
            sink_cnt  = 0;
            io_ack    = 1'b0;
        end else if (sink_en) begin
            if (io_req != sink_seen) begin
                sink_seen = io_req;
                sink_cnt  = 5;
            end else if (sink_cnt > 0) begin
                sink_cnt--;
                if (sink_cnt == 0) begin
                    io_ack  = ~io_ack;
                    ack_cyc = cyc;
                end
            end
        end
    end

    // Monitor: every req toggle launches exactly one scoreboard word, held until ready.
    always begin
        @(posedge clock);
        #1;
        if (!reset) begin
            mon_req = 1'b0;
        end else if (io_req !== mon_req) begin
            mon_req = io_req;
            req_log.push_back(io_req);
            chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_data = exp_q.pop_front();
                chk("launched_word", 32'(io_data), 32'(mon_data));
            end
        end else if (!io_enq_ready) begin
            chk("data_stable_wait", 32'(io_data), 32'(mon_data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int first_ready;
        int idx;

        // Reset and idle hold
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(io_enq_ready), 32'd1);
        chk("rst_req", 32'(io_req), 32'd0);
        chk("rst_data", 32'(io_data), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ready", 32'(io_enq_ready), 32'd1);
            chk("idle_req", 32'(io_req), 32'd0);
            chk("idle_data", 32'(io_data), 32'd0);
        end

        // Reset two cycles into a transfer with no ack
        sink_en      = 1'b0;
        io_enq_valid = 1'b1;
        io_enq_bits  = 2'b11;
        exp_q.push_back(2'b11);
        tick();
        io_enq_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_req", 32'(io_req), 32'd1);
        chk("pre_rst_data", 32'(io_data), 32'h3);
        chk("pre_rst_ready", 32'(io_enq_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(io_req), 32'd0);
        chk("async_rst_data", 32'(io_data), 32'd0);
        chk("async_rst_ready", 32'(io_enq_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        req_log.delete();

        // Single word with the sink acking
        sink_en      = 1'b1;
        io_enq_valid = 1'b1;
        io_enq_bits  = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        io_enq_valid = 1'b0;
        chk("fire_req", 32'(io_req), 32'd1);
        chk("fire_data", 32'(io_data), 32'h2);
        chk("fire_ready", 32'(io_enq_ready), 32'd0);
        first_ready = -1;
        for (int i = 0; i < 40 && first_ready < 0; i++) begin
            tick();
            if (io_enq_ready) first_ready = cyc;
        end
        chk("single_ready_seen", 32'(first_ready >= 0), 32'd1);
        chk("ack_to_ready_edges", 32'(first_ready - (ack_cyc + 1)), 32'(SYNC_DEPTH));

        // Clean reset so the burst starts from req = 0
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        req_log.delete();

        // Back-to-back burst with io_enq_bits scrambled during WAIT_ACK
        idx          = 0;
        io_enq_valid = 1'b1;
        for (int i = 0; i < 200 && !(idx == 3 && io_enq_ready); i++) begin
            if (io_enq_ready && idx < 3) begin
                io_enq_valid = 1'b1;
                io_enq_bits  = words[idx];
                exp_q.push_back(words[idx]);
                idx++;
            end else begin
                io_enq_valid = (idx < 3);
                io_enq_bits  = WIDTH'($urandom);
            end
            tick();
        end
        io_enq_valid = 1'b0;
        chk("burst_words_sent", 32'(idx), 32'd3);
        chk("burst_end_ready", 32'(io_enq_ready), 32'd1);
        chk("burst_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("burst_req_count", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) begin
            chk("burst_req0", 32'(req_log[0]), 32'd1);
            chk("burst_req1", 32'(req_log[1]), 32'd0);
            chk("burst_req2", 32'(req_log[2]), 32'd1);
        end

`ifdef ASYNC_CROSSING_SOURCE_TIMEOUT_EN
        // Timeout with the sink silent, then a late ack
        sink_en      = 1'b0;
        io_enq_valid = 1'b1;
        io_enq_bits  = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        io_enq_valid = 1'b0;
        chk("to_after_fire", 32'(io_timeout), 32'd0);
        repeat (7) tick();
        chk("to_before_limit", 32'(io_timeout), 32'd0);
        tick();
        chk("to_at_limit", 32'(io_timeout), 32'd1);
        chk("to_still_waiting", 32'(io_enq_ready), 32'd0);
        sink_en = 1'b1;
        first_ready = -1;
        for (int i = 0; i < 40 && first_ready < 0; i++) begin
            tick();
            if (io_enq_ready) first_ready = cyc;
        end
        chk("to_late_ack_ready", 32'(first_ready >= 0), 32'd1);
        chk("to_sticky", 32'(io_timeout), 32'd1);
        repeat (3) tick();
        chk("to_sticky_idle", 32'(io_timeout), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
